// File: rtl/trig_echo_sched.sv
// Frame scheduler for two ultrasonic range sensors: triggers each sensor in turn,
// times its echo in microseconds and reports the result with a one-cycle strobe.
module trig_echo_sched #(
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned US_CYCLES      = 100,
    parameter int unsigned TIMEOUT_CYCLES = 3000000,
    parameter int unsigned GAP_CYCLES     = 500000,
    parameter int unsigned TICK_CYCLES    = 5000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [3:0]  period_sel_i,
    input  logic [1:0]  echo_i,
    output logic [1:0]  trig_o,
    output logic [15:0] echo_us_o,
    output logic        echo_id_o,
    output logic        echo_valid_o,
    output logic        timeout_o,
    output logic        overrun_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StDone,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [3:0]  per_q, per_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] phase_cnt_q, phase_cnt_d;
    logic [21:0] to_cnt_q, to_cnt_d;
    logic [31:0] pre_cnt_q, pre_cnt_d;
    logic [15:0] us_cnt_q, us_cnt_d;
    logic [15:0] echo_us_q, echo_us_d;
    logic        echo_id_q, echo_id_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [1:0]  sync1_q, sync2_q;

    logic [31:0] frame_limit;
    logic        frame_tick;
    logic        echo_s;
    logic        to_hit;

    assign frame_limit = ({28'd0, per_q} + 32'd1) * TICK_CYCLES - 32'd1;
    assign frame_tick  = enable_i && (frame_cnt_q == 32'd0);
    assign echo_s      = sync2_q[sel_q];
    assign to_hit      = (to_cnt_q == 22'(TIMEOUT_CYCLES - 1));

    always_comb begin
        if (!enable_i) begin
            frame_cnt_d = 32'd0;
        end else if (frame_cnt_q >= frame_limit) begin
            frame_cnt_d = 32'd0;
        end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        per_d       = per_q;
        phase_cnt_d = phase_cnt_q;
        to_cnt_d    = to_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        us_cnt_d    = us_cnt_q;
        echo_us_d   = echo_us_q;
        echo_id_d   = echo_id_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = frame_tick && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    per_d       = period_sel_i;
                    sel_d       = 1'b0;
                    phase_cnt_d = 32'd0;
                    state_d     = StTrig;
                end
            end
            StTrig: begin
                if (phase_cnt_q == TRIG_CYCLES - 1) begin
                    phase_cnt_d = 32'd0;
                    to_cnt_d    = 22'd0;
                    state_d     = StWaitRise;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            StWaitRise: begin
                to_cnt_d = to_cnt_q + 22'd1;
                if (to_hit) begin
                    echo_us_d = 16'hFFFF;
                    echo_id_d = sel_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else if (echo_s) begin
                    us_cnt_d  = 16'd0;
                    pre_cnt_d = 32'd0;
                    state_d   = StMeasure;
                end
            end
            StMeasure: begin
                to_cnt_d = to_cnt_q + 22'd1;
                if (pre_cnt_q == US_CYCLES - 1) begin
                    pre_cnt_d = 32'd0;
                    if (us_cnt_q != 16'hFFFF) begin
                        us_cnt_d = us_cnt_q + 16'd1;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + 32'd1;
                end
                // An echo fall coinciding with the timeout still yields a real width.
                if (!echo_s) begin
                    echo_us_d = us_cnt_q;
                    echo_id_d = sel_q;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end else if (to_hit) begin
                    echo_us_d = 16'hFFFF;
                    echo_id_d = sel_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (!sel_q) begin
                    phase_cnt_d = 32'd0;
                    state_d     = StGap;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (phase_cnt_q == GAP_CYCLES - 1) begin
                    phase_cnt_d = 32'd0;
                    sel_d       = 1'b1;
                    state_d     = StTrig;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disabling aborts the frame and discards any result computed this cycle.
        if (!enable_i) begin
            state_d   = StIdle;
            sel_d     = 1'b0;
            echo_us_d = echo_us_q;
            echo_id_d = echo_id_q;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            per_q       <= 4'd0;
            frame_cnt_q <= 32'd0;
            phase_cnt_q <= 32'd0;
            to_cnt_q    <= 22'd0;
            pre_cnt_q   <= 32'd0;
            us_cnt_q    <= 16'd0;
            echo_us_q   <= 16'd0;
            echo_id_q   <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            per_q       <= per_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            us_cnt_q    <= us_cnt_d;
            echo_us_q   <= echo_us_d;
            echo_id_q   <= echo_id_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            sync1_q     <= echo_i;
            sync2_q     <= sync1_q;
        end
    end

    always_comb begin
        trig_o = 2'b00;
        if (state_q == StTrig) begin
            trig_o[sel_q] = 1'b1;
        end
    end

    assign echo_us_o    = echo_us_q;
    assign echo_id_o    = echo_id_q;
    assign echo_valid_o = valid_q;
    assign timeout_o    = timeout_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != StIdle);

endmodule
